// File: rtl/eth_len_pkg.sv
// Shared length-path definitions for the Ethernet RX/TX length FIFOs.
// Holds the frame size limits, the descriptor width and the framer state type.
package eth_len_pkg;

  localparam int ETH_MIN_PACKET_LENGTH = 64;
  localparam int ETH_MAX_PACKET_LENGTH = 1522;
  localparam int LENGTH_WIDTH =
    $clog2(ETH_MAX_PACKET_LENGTH);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } len_state_e;

endpackage

// File: rtl/eth_tx_length_framer.sv
// TX length framer: joins a length descriptor stream and an unframed byte
// stream into an 8-bit AXI-stream with tlast on each packet's final byte.
// Ports:
//   logic_clk, logic_rst_n      clock, synchronous active-low reset
//   tx_length_t*                length descriptor in (valid/ready)
//   s_axis_t*                   payload bytes in (valid/ready, no tlast)
//   m_axis_t*                   framed bytes out (data/valid/ready/last/user)
//   frame_done                  pulse after the last byte leaves
//   bad_length, bad_length_count  illegal descriptor pulse / saturating count
module eth_tx_length_framer #(
  parameter int LENGTH_WIDTH    = 11,
  parameter int MIN_LENGTH      = 1,
  parameter int MAX_LENGTH      = 1522,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                       logic_clk,
  input  logic                       logic_rst_n,
  input  logic [LENGTH_WIDTH-1:0]    tx_length_tdata,
  input  logic                       tx_length_tvalid,
  output logic                       tx_length_tready,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic                       frame_done,
  output logic                       bad_length,
  output logic [ERR_COUNT_WIDTH-1:0] bad_length_count
);

  import eth_len_pkg::*;

  localparam logic [LENGTH_WIDTH-1:0] MIN_L =
    LENGTH_WIDTH'(MIN_LENGTH);
  localparam logic [LENGTH_WIDTH-1:0] MAX_L =
    LENGTH_WIDTH'(MAX_LENGTH);
  localparam logic [LENGTH_WIDTH-1:0] ONE_L =
    LENGTH_WIDTH'(1);

  len_state_e                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0]     rem_q, rem_d;
  logic [7:0]                  data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        done_q, done_d;
  logic                        bad_q, bad_d;
  logic [ERR_COUNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic desc_hs;
  logic pay_hs;
  logic out_hs;
  logic len_ok;
  logic last_beat;

  assign tx_length_tready = (state_q == IDLE);
  // Single output register: refill whenever it is empty
  // or being drained this cycle.
  assign s_axis_tready = (state_q == PAYLOAD) &&
                         (!valid_q || m_axis_tready);

  assign desc_hs = tx_length_tvalid && tx_length_tready;
  assign pay_hs  = s_axis_tvalid && s_axis_tready;
  assign out_hs  = valid_q && m_axis_tready;

  assign len_ok = (tx_length_tdata >= MIN_L) &&
                  (tx_length_tdata <= MAX_L);
  assign last_beat = (rem_q == ONE_L);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (desc_hs && len_ok) begin
          rem_d   = tx_length_tdata;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pay_hs) begin
          rem_d = rem_q - ONE_L;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (pay_hs) begin
      data_d  = s_axis_tdata;
      valid_d = 1'b1;
      last_d  = last_beat;
    end else if (out_hs) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_comb begin
    done_d = out_hs && last_q;
    bad_d  = desc_hs && !len_ok;
    cnt_d  = cnt_q;
    if (bad_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_axis_tdata     = data_q;
  assign m_axis_tvalid    = valid_q;
  assign m_axis_tlast     = last_q;
  assign m_axis_tuser     = 1'b0;
  assign frame_done       = done_q;
  assign bad_length       = bad_q;
  assign bad_length_count = cnt_q;

endmodule
